// File: rtl/adiv_pkg.sv
// Shared types and defaults for the approximate sequential divider.
// Build option: ADIV_DIV0_EN adds the div0 flag to the bus and datapath.
package adiv_pkg;

    localparam int K_DEF = 6;
    localparam int N_DEF = 8;
    localparam int M_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEG   = 3'd1,
        ST_DIV   = 3'd2,
        ST_SCALE = 3'd3,
        ST_DONE  = 3'd4
    } adiv_state_t;

    // Width of the restoring-division iteration counter (2K iterations).
    function automatic int iter_w(input int k);
        return $clog2(2 * k);
    endfunction

    localparam int ITER_W_DEF = iter_w(K_DEF);

    // Width able to hold any leading-one position of either operand.
    function automatic int pos_w(input int n, input int m, input int k);
        int xw;
        xw = (n > m) ? n : m;
        xw = (k > xw) ? k : xw;
        return $clog2(xw) + 1;
    endfunction

endpackage

// File: rtl/adiv_seq_if.sv
// Operand/result handshake bundle for adiv_seq.
// Build option: ADIV_DIV0_EN adds the div0 result flag.
interface adiv_seq_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] q;
`ifdef ADIV_DIV0_EN
    logic         div0;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, q, div0);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, q, div0);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, q);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, q);
`endif
endinterface

// File: rtl/adiv_lod_trunc.sv
// Leading-one detect on a magnitude, then extraction of a K-bit segment
// (leading one, next K-2 bits, forced trailing one) and its shift offset.
module adiv_lod_trunc #(
    parameter int W  = 8,
    parameter int K  = 6,
    parameter int PW = 4
) (
    input  logic [W-1:0]  mag,
    output logic [K-1:0]  seg,
    output logic [PW-1:0] pos
);
    localparam int XW = (W > K) ? W : K;

    logic [XW-1:0] ext_s;
    logic [PW-1:0] lead_s;
    logic [K-1:0]  sh_s;

    assign ext_s = XW'(mag);

    // Highest set bit wins; an all-zero magnitude reports position 0.
    always_comb begin
        lead_s = '0;
        for (int i = 0; i < XW; i++) begin
            if (ext_s[i]) begin
                lead_s = PW'(i);
            end else begin
                lead_s = lead_s;
            end
        end
    end

    // Long operands are shifted down so the leading one lands in bit K-1.
    always_comb begin
        pos  = '0;
        sh_s = '0;
        seg  = '0;
        if (lead_s > PW'(K - 1)) begin
            pos  = lead_s - PW'(K - 1);
            sh_s = K'(ext_s >> pos);
            seg  = sh_s | {{(K-1){1'b0}}, 1'b1};
        end else begin
            seg  = ext_s[K-1:0];
        end
    end

endmodule

// File: rtl/adiv_seq.sv
// Approximate ones'-complement divider: segment both operands, restoring-divide
// the segments one bit per cycle, then rescale and saturate. ADIV_DIV0_EN adds div0.
module adiv_seq
    import adiv_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    adiv_seq_if.slave  bus
);
    localparam int CW = iter_w(K);
    localparam int PW = pos_w(N, M, K);
    localparam int WW = 2 * K + N;
    localparam logic [N-1:0] Q_MAX = {1'b0, {(N-1){1'b1}}};

    adiv_state_t    state_r;
    adiv_state_t    state_nx;

    logic [N-1:0]   a_r;
    logic [M-1:0]   b_r;
    logic [N-1:0]   a_mag_s;
    logic [M-1:0]   b_mag_s;
    logic           sign_s;
    logic [K-1:0]   a_seg_s;
    logic [K-1:0]   b_seg_s;
    logic [PW-1:0]  pa_s;
    logic [PW-1:0]  pb_s;

    logic [K-1:0]   b_seg_r;
    logic [PW-1:0]  pa_r;
    logic [PW-1:0]  pb_r;
    logic           b_zero_r;
    logic [2*K-1:0] dvd_r;
    logic [2*K-1:0] q_raw_r;
    logic [K-1:0]   rem_r;
    logic [CW-1:0]  cnt_r;

    logic [K:0]     trial_s;
    logic           ge_s;
    logic [K-1:0]   diff_s;

    int             s_s;
    logic [WW-1:0]  wide_s;
    logic [N-1:0]   q_mag_s;

    logic [N-1:0]   q_r;
    logic           in_ready_r;
    logic           out_valid_r;
`ifdef ADIV_DIV0_EN
    logic           div0_r;
`endif

    assign a_mag_s = a_r[N-1] ? ~a_r : a_r;
    assign b_mag_s = b_r[M-1] ? ~b_r : b_r;
    assign sign_s  = a_r[N-1] ^ b_r[M-1];

    adiv_lod_trunc #(.W(N), .K(K), .PW(PW)) u_lod_a (
        .mag (a_mag_s),
        .seg (a_seg_s),
        .pos (pa_s)
    );

    adiv_lod_trunc #(.W(M), .K(K), .PW(PW)) u_lod_b (
        .mag (b_mag_s),
        .seg (b_seg_s),
        .pos (pb_s)
    );

    assign trial_s = {rem_r, dvd_r[2*K-1]};
    assign ge_s    = (trial_s >= {1'b0, b_seg_r});
    assign diff_s  = K'(trial_s - {1'b0, b_seg_r});

    // Rescale the raw quotient; left shifts are clamped since anything past N bits saturates.
    always_comb begin
        s_s     = int'(pa_r) - int'(pb_r) - K;
        wide_s  = '0;
        q_mag_s = '0;
        if (b_zero_r) begin
            q_mag_s = Q_MAX;
        end else begin
            if (s_s >= 0) begin
                wide_s = WW'(q_raw_r) << ((s_s > N) ? N : s_s);
            end else begin
                wide_s = WW'(q_raw_r >> (-s_s));
            end
            if (wide_s > WW'(Q_MAX)) begin
                q_mag_s = Q_MAX;
            end else begin
                q_mag_s = wide_s[N-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) state_nx = ST_SEG;
                else              state_nx = ST_IDLE;
            end
            ST_SEG:   state_nx = ST_DIV;
            ST_DIV: begin
                if (cnt_r == CW'(2 * K - 1)) state_nx = ST_SCALE;
                else                         state_nx = ST_DIV;
            end
            ST_SCALE: state_nx = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) state_nx = ST_IDLE;
                else               state_nx = ST_DONE;
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Datapath: capture, segment, restoring division, final result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            b_seg_r  <= '0;
            pa_r     <= '0;
            pb_r     <= '0;
            b_zero_r <= 1'b0;
            dvd_r    <= '0;
            q_raw_r  <= '0;
            rem_r    <= '0;
            cnt_r    <= '0;
            q_r      <= '0;
`ifdef ADIV_DIV0_EN
            div0_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_r <= bus.a;
                        b_r <= bus.b;
                    end
                end
                ST_SEG: begin
                    b_seg_r  <= b_seg_s;
                    pa_r     <= pa_s;
                    pb_r     <= pb_s;
                    b_zero_r <= (b_mag_s == '0);
                    dvd_r    <= {a_seg_s, {K{1'b0}}};
                    q_raw_r  <= '0;
                    rem_r    <= '0;
                    cnt_r    <= '0;
                end
                ST_DIV: begin
                    cnt_r <= cnt_r + CW'(1);
                    // A zero divisor just idles through the iterations.
                    if (!b_zero_r) begin
                        dvd_r   <= {dvd_r[2*K-2:0], 1'b0};
                        rem_r   <= ge_s ? diff_s : trial_s[K-1:0];
                        q_raw_r <= {q_raw_r[2*K-2:0], ge_s};
                    end
                end
                ST_SCALE: begin
                    q_r    <= sign_s ? ~q_mag_s : q_mag_s;
`ifdef ADIV_DIV0_EN
                    div0_r <= b_zero_r;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake flags follow the next state so they change on the same edge as it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx == ST_IDLE);
            out_valid_r <= (state_nx == ST_DONE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.q         = q_r;
`ifdef ADIV_DIV0_EN
    assign bus.div0      = div0_r;
`endif

endmodule

// File: tb/tb_adiv_seq.sv
// Directed bench for adiv_seq at K=6, N=8, M=4; div0 checks need ADIV_DIV0_EN.
module tb_adiv_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    adiv_seq_if #(.N(8), .M(4)) bus ();

    adiv_seq #(.K(6), .N(8), .M(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_ovfall"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_irdy"},   32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [3:0] bv,
                          input logic [7:0] qx, input logic dzx, input bit hold);
        int cyc;
        logic [7:0] mag;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'd14);
        chk({tag, "_q"},   32'(bus.q), 32'(qx));
`ifdef ADIV_DIV0_EN
        chk({tag, "_div0"}, 32'(bus.div0), 32'(dzx));
`else
        mag = bus.q[7] ? ~bus.q : bus.q;
        if (dzx) chk({tag, "_sat"}, 32'(mag), 32'h7F);
`endif
        if (!hold) release_out(tag);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 8'd0;
        bus.b         = 4'd0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irdy", 32'(bus.in_ready),  32'd1);
        chk("rst_ov",   32'(bus.out_valid), 32'd0);
        chk("rst_q",    32'(bus.q),         32'd0);
`ifdef ADIV_DIV0_EN
        chk("rst_div0", 32'(bus.div0),      32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_op("d100_3",  8'd100, 4'd3,    8'd34,  1'b0, 1'b0);
        run_op("d20_m4",  8'd20,  4'b1011, 8'hFA,  1'b0, 1'b0);
        run_op("d50_0",   8'd50,  4'd0,    8'h7F,  1'b1, 1'b0);
        run_op("dm50_0",  8'hCD,  4'd0,    8'h80,  1'b1, 1'b0);
        run_op("d10_nz",  8'd10,  4'hF,    8'h80,  1'b1, 1'b0);
        run_op("d0_3",    8'd0,   4'd3,    8'h00,  1'b0, 1'b0);
        run_op("d127_1",  8'd127, 4'd1,    8'h7E,  1'b0, 1'b0);
        run_op("dm127_1", 8'h80,  4'd1,    8'h81,  1'b0, 1'b0);
        run_op("d64_5",   8'd64,  4'd5,    8'd13,  1'b0, 1'b0);

        // Backpressure: result must hold and new operands must be ignored.
        run_op("bp", 8'd100, 4'd3, 8'd34, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 2 == 0);
            bus.a        = 8'(20 + i);
            bus.b        = 4'd4;
            @(posedge clk);
            #1;
            chk("bp_q",    32'(bus.q),         32'd34);
            chk("bp_ov",   32'(bus.out_valid), 32'd1);
            chk("bp_irdy", 32'(bus.in_ready),  32'd0);
        end
        bus.in_valid = 1'b0;
        release_out("bp");
        repeat (3) @(posedge clk);
        #1;
        chk("bp_idle_ov",   32'(bus.out_valid), 32'd0);
        chk("bp_idle_irdy", 32'(bus.in_ready),  32'd1);

        // Reset five cycles into the division phase aborts the operation.
        @(negedge clk);
        bus.a        = 8'd100;
        bus.b        = 4'd3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rr_ov",   32'(bus.out_valid), 32'd0);
        chk("rr_irdy", 32'(bus.in_ready),  32'd1);
        chk("rr_q",    32'(bus.q),         32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rr_noq", 32'(bus.out_valid), 32'd0);
        run_op("rr_20_4", 8'd20, 4'd4, 8'd5, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adiv_seq.md
ADIV_SEQ -- requirements
Module: adiv_seq

Interface
REQ-001 Parameter K, default 6, segment width in bits (K>=4).
REQ-002 Parameter N, default 8, dividend and quotient width.
REQ-003 Parameter M, default 4, divisor width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block idle and able to accept operands.
REQ-008 a  input  N  dividend, ones'-complement signed.
REQ-009 b  input  M  divisor, ones'-complement signed.
REQ-010 out_valid  output  1  quotient valid.
REQ-011 out_ready  input  1  consumer accepts quotient.
REQ-012 q  output  N  approximate quotient, ones'-complement signed.
REQ-013 div0  output  1  divisor magnitude was zero (present only under ADIV_DIV0_EN).

Function
REQ-014 Accept operands on a rising edge where in_valid and in_ready are both 1; register a, b.
REQ-015 Magnitude: a_mag = a[N-1] ? ~a : a; b_mag likewise; sign = a[N-1] ^ b[M-1].
REQ-016 Leading-one position ka of a_mag (0 when a_mag is 0); kb of b_mag likewise.
REQ-017 Segment: if ka > K-1 then a_seg = {1, a_mag[ka-1 -: K-2], 1}, pa = ka-(K-1); else a_seg = a_mag[K-1:0], pa = 0; b_seg, pb identically.
REQ-018 Core: q_raw = floor((a_seg << K) / b_seg), 2K-bit, computed by restoring division, one quotient bit per cycle, 2K cycles.
REQ-019 Scale: s = pa - pb - K (signed); q_mag = q_raw << s if s >= 0, else q_raw >> -s (truncating).
REQ-020 Saturate: q_mag > 2^(N-1)-1 yields 2^(N-1)-1.
REQ-021 b_mag = 0: skip division, q_mag = 2^(N-1)-1, latency unchanged.
REQ-022 a_mag = 0 with b_mag != 0: q_mag = 0.
REQ-023 Output q = sign ? ~q_mag : q_mag.
REQ-024 FSM states IDLE, SEG, DIV, SCALE, DONE; IDLE->SEG on accept; SEG->DIV after 1 cycle; DIV->SCALE after 2K cycles; SCALE->DONE after 1 cycle; DONE->IDLE on out_ready=1.
REQ-025 Latency: accept at edge t; out_valid rises after edge t+2K+2 (14 cycles at K=6).
REQ-026 in_ready = 1 only in IDLE; in_valid ignored in all other states.
REQ-027 q (and div0) held stable while out_valid=1 and out_ready=0.
REQ-028 out_valid falls on the edge where out_ready=1 in DONE; next accept earliest the following edge (no same-cycle turnaround).

Reset
REQ-029 rst_n low asynchronously forces IDLE, in_ready=1, out_valid=0, q=0, div0=0, clears datapath registers.
REQ-030 Reset in any state aborts the operation; no quotient is produced for it.

Configuration
REQ-031 Macro ADIV_DIV0_EN defined: div0 port exists, registered with q, 1 iff b_mag = 0.
REQ-032 ADIV_DIV0_EN undefined: no div0 port; quotient behaviour identical, including saturation.

Structure
REQ-033 Package adiv_pkg holds FSM state enum, default K/N/M constants and iteration-count width.
REQ-034 One sub-module adiv_lod_trunc (leading-one detect plus segment/shift extraction) instantiated once each for a and b.

Verification (K=6, N=8, M=4)
REQ-035 a=8'd100, b=4'd3 -> q=8'd34 (a_seg=51, pa=1, q_raw=1088, s=-5), out_valid exactly 14 cycles after accept.
REQ-036 a=8'd20, b=4'b1011 (-4) -> q=8'hFA (~5).
REQ-037 a=8'd50, b=0 -> q=8'h7F, div0=1; a=8'hCD (-50), b=0 -> q=8'h80.
REQ-038 out_ready held 0 for 5 cycles in DONE -> q stable, in_ready=0, toggling in_valid with new operands has no effect.
REQ-039 rst_n pulsed low 5 cycles into DIV -> out_valid=0, in_ready=1 immediately; next op a=8'd20, b=4'd4 -> q=8'd5.
